// File: rtl/mem_arb_pkg.sv
// Shared constants for the refill arbiter: FSM encoding, requester ids, width defaults.
package mem_arb_pkg;
  localparam int ADDR_W_DEF   = 32;
  localparam int LINE_W_DEF   = 128;
  localparam int OFFSET_W_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;
endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select for the two refill requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise DCache has fixed priority.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic icache_req,
  input  logic dcache_req,
`ifdef MEM_ARB_RR_EN
  input  logic rr_last,
`endif
  output logic grant_any,
  output logic winner
);

  always_comb begin
    grant_any = icache_req | dcache_req;
    winner    = dcache_req ? REQ_DCACHE : REQ_ICACHE;
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that was not granted last goes first.
    if (icache_req && dcache_req)
      winner = (rr_last == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
`endif
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one line-refill memory port between ICache and DCache, one transaction in flight.
// Grant policy: round-robin when MEM_ARB_RR_EN is defined, else DCache fixed priority.
module mem_refill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINE_W   = LINE_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic              icache_valid_req_i,
  output logic              icache_ready_o,
  output logic [LINE_W-1:0] icache_data_o,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic              dcache_valid_req_i,
  input  logic              dcache_we_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  output logic              dcache_ready_o,
  output logic [LINE_W-1:0] dcache_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_valid_req_o,
  output logic              mem_we_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_data_i
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  logic [1:0] state;
  logic       win_id;
  logic       grant_any;
  logic       winner;
`ifdef MEM_ARB_RR_EN
  logic       rr_last;
`endif

  mem_arb_grant u_grant (
    .icache_req (icache_valid_req_i),
    .dcache_req (dcache_valid_req_i),
`ifdef MEM_ARB_RR_EN
    .rr_last    (rr_last),
`endif
    .grant_any  (grant_any),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      win_id          <= REQ_ICACHE;
`ifdef MEM_ARB_RR_EN
      rr_last         <= REQ_ICACHE;
`endif
      mem_addr_o      <= '0;
      mem_valid_req_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_wdata_o     <= '0;
      icache_ready_o  <= 1'b0;
      icache_data_o   <= '0;
      dcache_ready_o  <= 1'b0;
      dcache_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            win_id          <= winner;
            mem_valid_req_o <= 1'b1;
            state           <= ST_BUSY;
`ifdef MEM_ARB_RR_EN
            rr_last         <= winner;
`endif
            // Request fields are frozen here; requester changes during BUSY are ignored.
            if (winner == REQ_DCACHE) begin
              mem_addr_o  <= dcache_addr_i & LINE_MASK;
              mem_we_o    <= dcache_we_i;
              mem_wdata_o <= dcache_wdata_i;
            end else begin
              mem_addr_o  <= icache_addr_i & LINE_MASK;
              mem_we_o    <= 1'b0;
              mem_wdata_o <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready_i) begin
            mem_valid_req_o <= 1'b0;
            state           <= ST_RESP;
            if (win_id == REQ_DCACHE) begin
              dcache_ready_o <= 1'b1;
              if (!mem_we_o) dcache_data_o <= mem_data_i;
            end else begin
              icache_ready_o <= 1'b1;
              icache_data_o  <= mem_data_i;
            end
          end
        end
        ST_RESP: begin
          icache_ready_o <= 1'b0;
          dcache_ready_o <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
